stimulus_sequencer: RTL and testbench

STIMULUS_SEQUENCER -- requirements
Module: stimulus_sequencer

---
 rtl/stimulus_sequencer.sv | 128 ++++++++++++
 tb/tb_stimulus_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stimulus_sequencer.sv
// -----------------------------------------------------------------------------
// stimulus_sequencer
//
// Purpose:
//   Sweeps the 2-bit control pattern {a,b} through 00, 01, 10, 11. Each pattern
//   is held for DWELL clock cycles. The block drives the control operands of a
//   downstream gate module. A sweep starts on 'start' and can be cut short by
//   'abort'. 'done' pulses for one cycle when a sweep completes.
//
// Parameters:
//   DWELL  - cycles each pattern is held (1..255, default 2)
//
// Ports:
//   clk    in   1  single clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  begin a sweep (sampled on clk; ignored while busy)
//   abort  in   1  stop any sweep (sampled on clk; wins over start/completion)
//   a      out  1  first control operand  (step[1])
//   b      out  1  second control operand (step[0])
//   step   out  2  index of the current pattern
//   busy   out  1  high while a sweep is in progress
//   done   out  1  one-cycle pulse when a sweep completes
//
// Configuration:
//   STIMULUS_SEQUENCER_LOOP_EN - when defined, the sweep wraps from step 3
//   back to step 0 and keeps running. 'done' still pulses once per sweep and
//   'busy' stays high; only abort or reset leaves RUN. When undefined, the
//   block is one-shot.
// -----------------------------------------------------------------------------
module stimulus_sequencer #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic [1:0] step,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Terminal value of the dwell counter. The counter never passes it, so it
  // cannot overflow for any legal DWELL.
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg,   cnt_next;
  logic [1:0] step_reg,  step_next;
  logic       done_reg,  done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      step_reg  <= 2'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      step_reg  <= step_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    step_next  = step_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next  = 8'd0;
        step_next = 2'd0;
        // abort has priority over a simultaneous start.
        if (start && !abort) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          // Abort also wins over a completion in the same cycle, so no done.
          state_next = IDLE;
          cnt_next   = 8'd0;
          step_next  = 2'd0;
        end else if (cnt_reg == DWELL_LAST) begin
          cnt_next = 8'd0;
          if (step_reg == 2'd3) begin
            done_next = 1'b1;
            step_next = 2'd0;
`ifdef STIMULUS_SEQUENCER_LOOP_EN
            state_next = RUN;
`else
            state_next = IDLE;
`endif
          end else begin
            step_next = step_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
        step_next  = 2'd0;
      end
    endcase
  end

  // All outputs come straight from state registers. No input reaches an
  // output without passing through a flop.
  assign step = step_reg;
  assign a    = step_reg[1];
  assign b    = step_reg[0];
  assign busy = (state_reg == RUN);
  assign done = done_reg;

endmodule

// File: tb/tb_stimulus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stimulus_sequencer
//
// Self-checking bench for stimulus_sequencer. Three instances with DWELL = 2, 1
// and 3 share the same start/abort/rst_n stimulus. The reference model tracks
// only whether a sweep is running and how many cycles have elapsed since it
// started. The expected step is derived arithmetically as (elapsed / DWELL) % 4.
// A completion occurs when elapsed reaches a multiple of 4*DWELL.
// Define STIMULUS_SEQUENCER_LOOP_EN on both RTL and bench to check
// continuous mode.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stimulus_sequencer;

  localparam int NI = 3;

  function automatic int dw_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic       a_w    [NI];
  logic       b_w    [NI];
  logic [1:0] step_w [NI];
  logic       busy_w [NI];
  logic       done_w [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      stimulus_sequencer #(
        .DWELL(dw_of(gi))
      ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .a     (a_w[gi]),
        .b     (b_w[gi]),
        .step  (step_w[gi]),
        .busy  (busy_w[gi]),
        .done  (done_w[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: sweep running flag, cycles since start, done flag.
  bit m_run  [NI];
  int m_el   [NI];
  bit m_done [NI];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_run[i]  = 1'b0;
      m_el[i]   = 0;
      m_done[i] = 1'b0;
    end
  endtask

  // Applies the start/abort values sampled at one rising edge.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (!m_run[i]) begin
        m_done[i] = 1'b0;
        if (start && !abort) begin
          m_run[i] = 1'b1;
          m_el[i]  = 0;
        end
      end else if (abort) begin
        m_run[i]  = 1'b0;
        m_done[i] = 1'b0;
      end else begin
        m_el[i]++;
        m_done[i] = ((m_el[i] % (4 * dw_of(i))) == 0);
`ifndef STIMULUS_SEQUENCER_LOOP_EN
        if (m_done[i]) m_run[i] = 1'b0;
`endif
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    logic [1:0] es;
    for (int i = 0; i < NI; i++) begin
      es = m_run[i] ? 2'((m_el[i] / dw_of(i)) % 4) : 2'd0;
      check_eq($sformatf("%s.d%0d.busy", ph, i), 32'(busy_w[i]), 32'(m_run[i]));
      check_eq($sformatf("%s.d%0d.done", ph, i), 32'(done_w[i]), 32'(m_done[i]));
      check_eq($sformatf("%s.d%0d.step", ph, i), 32'(step_w[i]), 32'(es));
      check_eq($sformatf("%s.d%0d.a",    ph, i), 32'(a_w[i]),    32'(es[1]));
      check_eq($sformatf("%s.d%0d.b",    ph, i), 32'(b_w[i]),    32'(es[0]));
    end
  endtask

  // Called at a falling edge. It drives the inputs, lets one rising edge pass,
  // and then checks all outputs at the next falling edge.
  task automatic cycle(input logic s, input logic ab);
    start = s;
    abort = ab;
    if (s || ab) $display("cyc %0d: start=%0b abort=%0b", cyc, s, ab);
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_outputs("cyc");
  endtask

  // Asserts reset between clock edges and checks that the outputs clear
  // without waiting for an edge. It then holds reset for two rising edges.
  task automatic async_reset(input logic s_during);
    $display("cyc %0d: async reset (start=%0b)", cyc, s_during);
    #2;
    rst_n = 1'b0;
    start = s_during;
    abort = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    repeat (2) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outputs("rst_hold");
    end
    rst_n = 1'b1;
    start = 1'b0;
  endtask

  // Runs one full sweep with a redundant start in the middle. Checks that each
  // instance produces exactly one done within the sweep, at 4*DWELL cycles
  // after the first post-start cycle.
  task automatic sweep_check();
    int cnt [NI];
    int at  [NI];
    $display("cyc %0d: directed sweep with mid-sweep restart", cyc);
    for (int i = 0; i < NI; i++) begin
      cnt[i] = 0;
      at[i]  = -1;
    end
    for (int j = 0; j < 14; j++) begin
      cycle((j == 0) || (j == 3), 1'b0);
      for (int i = 0; i < NI; i++) begin
        if (done_w[i] === 1'b1) begin
          if (j <= 4 * dw_of(i)) cnt[i]++;
          if (at[i] < 0) at[i] = j;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("sweep.d%0d.done_count", i), 32'(cnt[i]), 32'd1);
      check_eq($sformatf("sweep.d%0d.done_at", i), 32'(at[i]), 32'(4 * dw_of(i)));
    end
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) cycle(1'b0, 1'b0);

    sweep_check();

    // Abort partway through a sweep, then stay idle.
    cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0);

    // Start and abort together in IDLE: the block stays idle.
    cycle(1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b0);

    // Reset mid-sweep, with start held during reset.
    cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    async_reset(1'b1);
    repeat (14) cycle(1'b0, 1'b0);

    // Start on the first edge after reset release.
    async_reset(1'b0);
    cycle(1'b1, 1'b0);
    repeat (14) cycle(1'b0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset(1'($urandom_range(0, 1)));
      end else begin
        cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 19) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
